// File: rtl/d16_writeback_if.sv
// d16_writeback_if
//   Result and write-port bundle for the d16 writeback block.
//
//   Handshake (both result channels): a transfer happens in a cycle where
//   valid and ready are both high. The producer holds addr/data stable
//   while valid is high and ready is low. ready never depends on valid.
//
//   Signals:
//     alu_valid/alu_ready/alu_addr/alu_data : ALU result channel
//     mem_valid/mem_ready/mem_addr/mem_data : load result channel
//     w/addr_w/data                         : register file write port
//
//   Modports:
//     slave  : the writeback block (accepts results, drives write port)
//     master : the producers / register-file side
interface d16_writeback_if;
    logic        alu_valid;
    logic        alu_ready;
    logic [3:0]  alu_addr;
    logic [15:0] alu_data;

    logic        mem_valid;
    logic        mem_ready;
    logic [3:0]  mem_addr;
    logic [15:0] mem_data;

    logic        w;
    logic [3:0]  addr_w;
    logic [15:0] data;

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        output alu_ready,
        input  mem_valid, mem_addr, mem_data,
        output mem_ready,
        output w, addr_w, data
    );

    modport master (
        output alu_valid, alu_addr, alu_data,
        input  alu_ready,
        output mem_valid, mem_addr, mem_data,
        input  mem_ready,
        input  w, addr_w, data
    );
endinterface

// File: rtl/d16_writeback.sv
// d16_writeback
//   Writeback arbiter and pending-write scoreboard for the d16 core.
//   ALU results are queued in a DEPTH-entry FIFO; load results go straight
//   to the register-file write port. One write per cycle is issued, with
//   load results preferred except that after STARVE_MAX consecutive load
//   wins over a non-empty FIFO the FIFO head is given one slot.
//
//   Optional feature: define D16_WB_BYPASS_EN to let an ALU result skip the
//   FIFO (1-cycle latency) when the FIFO is empty, no load is offered and no
//   starvation slot is pending.
//
//   Ports:
//     sys_clk    : clock, rising edge
//     sys_rst    : synchronous active-low reset
//     iss_stb    : instruction with register destination issues
//     iss_addr   : its destination register
//     busy       : per-register pending-write flags (registered)
//     fifo_level : ALU FIFO occupancy (registered)
//     wb         : ALU/load result channels and register-file write port
module d16_writeback #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic                     iss_stb,
    input  logic [3:0]               iss_addr,
    output logic [15:0]              busy,
    output logic [$clog2(DEPTH):0]   fifo_level,
    d16_writeback_if.slave           wb
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    // FIFO storage (no reset needed: validity is tracked by level)
    logic [15:0] fifo_data [DEPTH];
    logic [3:0]  fifo_addr [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   level;
    logic [SW-1:0] starve_cnt;

    logic        w_q;
    logic [3:0]  addr_w_q;
    logic [15:0] data_q;
    logic [15:0] busy_q;

    logic fifo_empty, fifo_full, starve_slot;
    logic alu_fire, mem_fire, bypass, push, pop;
    logic        win_v;
    logic [3:0]  win_addr;
    logic [15:0] win_data;
    logic [SW-1:0] starve_nxt;
    logic [15:0] set_mask, clr_mask;

    assign fifo_empty  = (level == '0);
    assign fifo_full   = (level == (AW+1)'(DEPTH));
    // Counter reached its limit while ALU results wait: head gets this slot.
    assign starve_slot = !fifo_empty && (starve_cnt >= SW'(STARVE_MAX));

    // Readies come from registered state and reset only.
    assign wb.alu_ready = sys_rst && !fifo_full;
    assign wb.mem_ready = sys_rst && !starve_slot;

    assign alu_fire = wb.alu_valid && wb.alu_ready;
    assign mem_fire = wb.mem_valid && wb.mem_ready;

`ifdef D16_WB_BYPASS_EN
    // Empty FIFO implies no starvation slot, so that condition is covered.
    assign bypass = alu_fire && fifo_empty && !wb.mem_valid;
`else
    assign bypass = 1'b0;
`endif

    assign push = alu_fire && !bypass;
    // The head goes out whenever memory does not take the port; during a
    // starvation slot mem_ready is low so mem_fire is already 0.
    assign pop  = !fifo_empty && !mem_fire;

    always_comb begin
        win_v    = 1'b0;
        win_addr = addr_w_q;
        win_data = data_q;
        if (mem_fire) begin
            win_v    = 1'b1;
            win_addr = wb.mem_addr;
            win_data = wb.mem_data;
        end else if (pop) begin
            win_v    = 1'b1;
            win_addr = fifo_addr[rd_ptr];
            win_data = fifo_data[rd_ptr];
        end else if (bypass) begin
            win_v    = 1'b1;
            win_addr = wb.alu_addr;
            win_data = wb.alu_data;
        end
    end

    always_comb begin
        starve_nxt = starve_cnt;
        if (fifo_empty || pop)
            starve_nxt = '0;
        else if (mem_fire)
            starve_nxt = starve_cnt + SW'(1);
    end

    // Set wins over clear when both target the same register.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (iss_stb) set_mask[iss_addr] = 1'b1;
        if (w_q)     clr_mask[addr_w_q] = 1'b1;
    end

    always_ff @(posedge sys_clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= wb.alu_data;
            fifo_addr[wr_ptr] <= wb.alu_addr;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            starve_cnt <= '0;
            w_q        <= 1'b0;
            addr_w_q   <= '0;
            data_q     <= '0;
            busy_q     <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
            starve_cnt <= starve_nxt;
            w_q        <= win_v;
            addr_w_q   <= win_addr;
            data_q     <= win_data;
            busy_q     <= (busy_q & ~clr_mask) | set_mask;
        end
    end

    assign wb.w       = w_q;
    assign wb.addr_w  = addr_w_q;
    assign wb.data    = data_q;
    assign busy       = busy_q;
    assign fifo_level = level;
endmodule

// File: tb/tb_d16_writeback.sv
module tb_d16_writeback;
    logic        sys_clk;
    logic        sys_rst;
    logic        iss_stb;
    logic [3:0]  iss_addr;
    logic [15:0] busy;
    logic [2:0]  fifo_level;

    d16_writeback_if bus ();

    d16_writeback #(.DEPTH(4), .STARVE_MAX(3)) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .iss_stb    (iss_stb),
        .iss_addr   (iss_addr),
        .busy       (busy),
        .fifo_level (fifo_level),
        .wb         (bus)
    );

    // ---------------- clock / reset ----------------
    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    int n_vec = 0;
    int n_bad = 0;
    logic [19:0] exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        iss;
        logic [3:0]  ia;
        logic        av;
        logic [3:0]  aa;
        logic [15:0] ad;
        logic        mv;
        logic [3:0]  ma;
        logic [15:0] md;
        logic        e_ar;
        logic        e_mr;
        logic        e_w;
        logic [3:0]  e_aw;
        logic [15:0] e_d;
        logic [15:0] e_busy;
        logic [2:0]  e_lvl;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(
        input logic rst, input logic iss, input logic [3:0] ia,
        input logic av, input logic [3:0] aa, input logic [15:0] ad,
        input logic mv, input logic [3:0] ma, input logic [15:0] md,
        input logic e_ar, input logic e_mr,
        input logic e_w, input logic [3:0] e_aw, input logic [15:0] e_d,
        input logic [15:0] e_busy, input logic [2:0] e_lvl);
        vec_t v;
        v.rst = rst; v.iss = iss; v.ia = ia;
        v.av = av; v.aa = aa; v.ad = ad;
        v.mv = mv; v.ma = ma; v.md = md;
        v.e_ar = e_ar; v.e_mr = e_mr;
        v.e_w = e_w; v.e_aw = e_aw; v.e_d = e_d;
        v.e_busy = e_busy; v.e_lvl = e_lvl;
        vecs.push_back(v);
    endtask

    // ---------------- driver ----------------
    task automatic drive(
        input logic rst, input logic iss, input logic [3:0] ia,
        input logic av, input logic [3:0] aa, input logic [15:0] ad,
        input logic mv, input logic [3:0] ma, input logic [15:0] md);
        sys_rst       = rst;
        iss_stb       = iss;
        iss_addr      = ia;
        bus.alu_valid = av;
        bus.alu_addr  = aa;
        bus.alu_data  = ad;
        bus.mem_valid = mv;
        bus.mem_addr  = ma;
        bus.mem_data  = md;
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    function automatic bit is_alu_slot(input int c);
        return (c == 4) || (c == 8) || (c == 12) || (c == 16) || (c == 19);
    endfunction

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // rst iss ia  av aa ad  mv ma md | ar mr | w aw d busy lvl
        // reset with both valids high
        add_vec(0,0,4'h0, 1,4'h9,16'h9999, 1,4'h9,16'h8888, 0,0, 0,4'h0,16'h0000,16'h0000,3'd0);
        add_vec(0,0,4'h0, 1,4'h9,16'h9999, 1,4'h9,16'h8888, 0,0, 0,4'h0,16'h0000,16'h0000,3'd0);
        add_vec(1,0,4'h0, 0,4'h0,16'h0000, 0,4'h0,16'h0000, 1,1, 0,4'h0,16'h0000,16'h0000,3'd0);
        // single ALU op to r3
        add_vec(1,1,4'h3, 0,4'h0,16'h0000, 0,4'h0,16'h0000, 1,1, 0,4'h0,16'h0000,16'h0008,3'd0);
`ifdef D16_WB_BYPASS_EN
        add_vec(1,0,4'h0, 1,4'h3,16'h1234, 0,4'h0,16'h0000, 1,1, 1,4'h3,16'h1234,16'h0008,3'd0);
        add_vec(1,0,4'h0, 0,4'h0,16'h0000, 0,4'h0,16'h0000, 1,1, 0,4'h3,16'h1234,16'h0000,3'd0);
        add_vec(1,0,4'h0, 0,4'h0,16'h0000, 0,4'h0,16'h0000, 1,1, 0,4'h3,16'h1234,16'h0000,3'd0);
`else
        add_vec(1,0,4'h0, 1,4'h3,16'h1234, 0,4'h0,16'h0000, 1,1, 0,4'h0,16'h0000,16'h0008,3'd1);
        add_vec(1,0,4'h0, 0,4'h0,16'h0000, 0,4'h0,16'h0000, 1,1, 1,4'h3,16'h1234,16'h0008,3'd0);
        add_vec(1,0,4'h0, 0,4'h0,16'h0000, 0,4'h0,16'h0000, 1,1, 0,4'h3,16'h1234,16'h0000,3'd0);
`endif
        // load to r5, then re-issue r5 in the cycle its write is on the port
        add_vec(1,1,4'h5, 0,4'h0,16'h0000, 1,4'h5,16'h5555, 1,1, 1,4'h5,16'h5555,16'h0020,3'd0);
        add_vec(1,1,4'h5, 0,4'h0,16'h0000, 0,4'h0,16'h0000, 1,1, 0,4'h5,16'h5555,16'h0020,3'd0);
        add_vec(1,0,4'h0, 0,4'h0,16'h0000, 1,4'h5,16'h0055, 1,1, 1,4'h5,16'h0055,16'h0020,3'd0);
        add_vec(1,0,4'h0, 0,4'h0,16'h0000, 0,4'h0,16'h0000, 1,1, 0,4'h5,16'h0055,16'h0000,3'd0);
        // ALU and load in the same cycle: load first, ALU next
        add_vec(1,0,4'h0, 1,4'h7,16'h0777, 1,4'h6,16'h0666, 1,1, 1,4'h6,16'h0666,16'h0000,3'd1);
        add_vec(1,0,4'h0, 0,4'h0,16'h0000, 0,4'h0,16'h0000, 1,1, 1,4'h7,16'h0777,16'h0000,3'd0);
        add_vec(1,0,4'h0, 0,4'h0,16'h0000, 0,4'h0,16'h0000, 1,1, 0,4'h7,16'h0777,16'h0000,3'd0);
        // scoreboard edges r0 and r15
        add_vec(1,1,4'h0, 0,4'h0,16'h0000, 0,4'h0,16'h0000, 1,1, 0,4'h7,16'h0777,16'h0001,3'd0);
        add_vec(1,1,4'hf, 0,4'h0,16'h0000, 1,4'h0,16'h0f0f, 1,1, 1,4'h0,16'h0f0f,16'h8001,3'd0);
        add_vec(1,0,4'h0, 0,4'h0,16'h0000, 0,4'h0,16'h0000, 1,1, 0,4'h0,16'h0f0f,16'h8000,3'd0);
        add_vec(1,0,4'h0, 0,4'h0,16'h0000, 1,4'hf,16'hf00f, 1,1, 1,4'hf,16'hf00f,16'h8000,3'd0);
        add_vec(1,0,4'h0, 0,4'h0,16'h0000, 0,4'h0,16'h0000, 1,1, 0,4'hf,16'hf00f,16'h0000,3'd0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].iss, vecs[i].ia, vecs[i].av, vecs[i].aa,
                  vecs[i].ad, vecs[i].mv, vecs[i].ma, vecs[i].md);
            #1;
            chk($sformatf("v%0d alu_ready", i), 32'(bus.alu_ready), 32'(vecs[i].e_ar));
            chk($sformatf("v%0d mem_ready", i), 32'(bus.mem_ready), 32'(vecs[i].e_mr));
            tick();
            chk($sformatf("v%0d w", i),      32'(bus.w),      32'(vecs[i].e_w));
            chk($sformatf("v%0d addr_w", i), 32'(bus.addr_w), 32'(vecs[i].e_aw));
            chk($sformatf("v%0d data", i),   32'(bus.data),   32'(vecs[i].e_d));
            chk($sformatf("v%0d busy", i),   32'(busy),       32'(vecs[i].e_busy));
            chk($sformatf("v%0d level", i),  32'(fifo_level), 32'(vecs[i].e_lvl));
        end

        // ---- contention + FIFO full: load stream r1=AAAA, five ALU results ----
        for (int i = 0; i < 5; i++)
            exp_q.push_back({4'(8 + i), 16'(16'h1000 + i)});
        for (int c = 0; c <= 20; c++) begin
            logic        av;
            logic [3:0]  aa;
            logic [15:0] ad;
            av = 1'b0; aa = 4'h0; ad = 16'h0000;
            if (c < 4) begin
                av = 1'b1; aa = 4'(8 + c); ad = 16'(16'h1000 + c);
            end else if (c == 4 || c == 5) begin
                av = 1'b1; aa = 4'hc; ad = 16'h1004;
            end
            drive(1, 0, 0, av, aa, ad, (c <= 18), 4'h1, 16'haaaa);
            #1;
            if (c == 4) begin
                chk("full level", 32'(fifo_level), 32'd4);
                chk("full alu_ready", 32'(bus.alu_ready), 32'd0);
            end
            if (c == 5)
                chk("after pop alu_ready", 32'(bus.alu_ready), 32'd1);
            if (c <= 18)
                chk($sformatf("cont c%0d mem_ready", c), 32'(bus.mem_ready),
                    is_alu_slot(c) ? 32'd0 : 32'd1);
            tick();
            if (c <= 19) begin
                chk($sformatf("cont c%0d w", c), 32'(bus.w), 32'd1);
                if (is_alu_slot(c)) begin
                    if (exp_q.size() == 0)
                        chk($sformatf("cont c%0d queue", c), 32'd0, 32'd1);
                    else
                        chk($sformatf("cont c%0d alu write", c),
                            32'({bus.addr_w, bus.data}), 32'(exp_q.pop_front()));
                end else begin
                    chk($sformatf("cont c%0d mem write", c),
                        32'({bus.addr_w, bus.data}), 32'({4'h1, 16'haaaa}));
                end
            end else begin
                chk("cont idle w", 32'(bus.w), 32'd0);
            end
            if (c == 19)
                chk("cont drained level", 32'(fifo_level), 32'd0);
        end
        chk("cont leftover", 32'(exp_q.size()), 32'd0);

        // ---- mid-operation reset with three ALU results queued ----
        for (int c = 0; c < 3; c++) begin
            drive(1, (c == 0), 4'hc, 1'b1, 4'hc, 16'(16'hde00 + c), 1'b1, 4'h2, 16'hbbbb);
            tick();
        end
        chk("mrst queued level", 32'(fifo_level), 32'd3);
        chk("mrst busy before", 32'(busy), 32'h1000);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("mrst alu_ready", 32'(bus.alu_ready), 32'd0);
        chk("mrst mem_ready", 32'(bus.mem_ready), 32'd0);
        tick();
        chk("mrst w", 32'(bus.w), 32'd0);
        chk("mrst level", 32'(fifo_level), 32'd0);
        chk("mrst busy", 32'(busy), 32'd0);
        chk("mrst addr_w/data", 32'({bus.addr_w, bus.data}), 32'd0);
        for (int c = 0; c < 5; c++) begin
            drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
            tick();
            chk($sformatf("mrst idle%0d w", c), 32'(bus.w), 32'd0);
            chk($sformatf("mrst idle%0d level", c), 32'(fifo_level), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
